// File: rtl/nway_wb_cache_if.sv
// Bus bundle for nway_wb_cache: core load/store request/response plus the
// block-wide memory writeback/refill channel.
interface nway_wb_cache_if #(
    parameter int WORD_SIZE       = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int ADDR_WIDTH      = 32
);
    localparam int OFFSET_WIDTH = $clog2(WORDS_PER_BLOCK);
    localparam int BLOCK_SIZE   = WORDS_PER_BLOCK * WORD_SIZE;

    logic                               cpu_req_valid;
    logic                               cpu_req_ready;
    logic                               cpu_req_type;
    logic [ADDR_WIDTH-1:0]              cpu_addr;
    logic [WORD_SIZE-1:0]               cpu_wdata;
    logic                               cpu_resp_valid;
    logic [WORD_SIZE-1:0]               cpu_rdata;
    logic                               mem_req_valid;
    logic                               mem_req_ready;
    logic                               mem_req_we;
    logic [ADDR_WIDTH-OFFSET_WIDTH-1:0] mem_addr;
    logic [BLOCK_SIZE-1:0]              mem_wdata;
    logic                               mem_resp_valid;
    logic [BLOCK_SIZE-1:0]              mem_rdata;

    // Cache side
    modport slave (
        input  cpu_req_valid, cpu_req_type, cpu_addr, cpu_wdata,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output cpu_req_ready, cpu_resp_valid, cpu_rdata,
        output mem_req_valid, mem_req_we, mem_addr, mem_wdata
    );

    // Core + memory side
    modport master (
        output cpu_req_valid, cpu_req_type, cpu_addr, cpu_wdata,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  cpu_req_ready, cpu_resp_valid, cpu_rdata,
        input  mem_req_valid, mem_req_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/nway_wb_cache.sv
// N-way set-associative write-back / write-allocate cache with true-LRU
// replacement and a miss FSM that sequences writeback and refill over a
// valid/ready memory channel.
module nway_wb_cache #(
    parameter int WORD_SIZE       = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int NUM_BLOCKS      = 64,
    parameter int NUM_WAYS        = 4,
    parameter int ADDR_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nway_wb_cache_if.slave       bus,
    output logic [31:0]          hit_cnt,
    output logic [31:0]          miss_cnt
);
    localparam int BLOCK_SIZE   = WORDS_PER_BLOCK * WORD_SIZE;
    localparam int NUM_SETS     = NUM_BLOCKS / NUM_WAYS;
    localparam int INDEX_WIDTH  = $clog2(NUM_SETS);
    localparam int OFFSET_WIDTH = $clog2(WORDS_PER_BLOCK);
    localparam int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int WAY_W        = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB_REQ, S_REFILL_REQ, S_REFILL_WAIT} state_t;

    state_t                  r_state, w_next;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_we;
    logic [WORD_SIZE-1:0]    r_wdata;
    logic [WAY_W-1:0]        r_victim;
    logic                    r_retry;
    logic                    r_resp_valid;
    logic [WORD_SIZE-1:0]    r_rdata;
    logic [31:0]             r_hit_cnt, r_miss_cnt;

    logic [NUM_WAYS-1:0]     r_valid [NUM_SETS];
    logic [NUM_WAYS-1:0]     r_dirty [NUM_SETS];
    logic [WAY_W-1:0]        r_age   [NUM_SETS][NUM_WAYS];
    logic [TAG_WIDTH-1:0]    r_tag   [NUM_SETS][NUM_WAYS];
    logic [BLOCK_SIZE-1:0]   r_data  [NUM_SETS][NUM_WAYS];

    logic [TAG_WIDTH-1:0]    w_tag;
    logic [INDEX_WIDTH-1:0]  w_idx;
    logic [OFFSET_WIDTH-1:0] w_off;
    logic                    w_hit, w_found_inv;
    logic [WAY_W-1:0]        w_hit_way, w_victim;
    logic [BLOCK_SIZE-1:0]   w_line, w_line_new;
    logic [WORD_SIZE-1:0]    w_merged;

    assign w_tag = r_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign w_idx = r_addr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign w_off = r_addr[OFFSET_WIDTH-1:0];

    // Tag compare across all valid ways of the latched set
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
        end
    end

    // Victim: lowest-numbered invalid way, otherwise the oldest way
    always_comb begin
        w_found_inv = 1'b0;
        w_victim    = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_idx][w]) begin
                w_found_inv = 1'b1;
                w_victim    = WAY_W'(w);
            end
        end
        if (!w_found_inv) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (r_age[w_idx][w] == WAY_W'(NUM_WAYS - 1)) w_victim = WAY_W'(w);
            end
        end
    end

    // Hit word selection and write merge
    always_comb begin
        w_line     = r_data[w_idx][w_hit_way];
        w_merged   = r_we ? r_wdata : w_line[w_off*WORD_SIZE +: WORD_SIZE];
        w_line_new = w_line;
        w_line_new[w_off*WORD_SIZE +: WORD_SIZE] = w_merged;
    end

    // Next-state and memory-channel outputs; request fields derive only from
    // registered state so they stay stable while a request is stalled
    always_comb begin
        w_next            = r_state;
        bus.mem_req_valid = 1'b0;
        bus.mem_req_we    = 1'b0;
        bus.mem_addr      = '0;
        bus.mem_wdata     = '0;
        case (r_state)
            S_IDLE:        if (bus.cpu_req_valid) w_next = S_LOOKUP;
            S_LOOKUP: begin
                if (w_hit)                                                   w_next = S_IDLE;
                else if (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim]) w_next = S_WB_REQ;
                else                                                         w_next = S_REFILL_REQ;
            end
            S_WB_REQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_we    = 1'b1;
                bus.mem_addr      = {r_tag[w_idx][r_victim], w_idx};
                bus.mem_wdata     = r_data[w_idx][r_victim];
                if (bus.mem_req_ready) w_next = S_REFILL_REQ;
            end
            S_REFILL_REQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_addr      = {w_tag, w_idx};
                if (bus.mem_req_ready) w_next = S_REFILL_WAIT;
            end
            S_REFILL_WAIT: if (bus.mem_resp_valid) w_next = S_LOOKUP;
            default:       w_next = S_IDLE;
        endcase
    end

    // FSM state, response, counters, valid/dirty/LRU bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
            r_retry      <= 1'b0;
            r_victim     <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) r_age[s][w] <= WAY_W'(w);
            end
        end else begin
            r_state      <= w_next;
            r_resp_valid <= 1'b0;
            case (r_state)
                S_LOOKUP: begin
                    if (w_hit) begin
                        r_resp_valid <= 1'b1;
                        r_rdata      <= w_merged;
                        r_retry      <= 1'b0;
                        if (r_we) r_dirty[w_idx][w_hit_way] <= 1'b1;
                        if (!r_retry && (r_hit_cnt != 32'hFFFF_FFFF)) r_hit_cnt <= r_hit_cnt + 32'd1;
                        if (NUM_WAYS > 1) begin
                            for (int w = 0; w < NUM_WAYS; w++) begin
                                if (WAY_W'(w) == w_hit_way)
                                    r_age[w_idx][w] <= '0;
                                else if (r_age[w_idx][w] < r_age[w_idx][w_hit_way])
                                    r_age[w_idx][w] <= r_age[w_idx][w] + 1'b1;
                            end
                        end
                    end else begin
                        if (r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
                        r_victim <= w_victim;
                    end
                end
                S_REFILL_WAIT: begin
                    if (bus.mem_resp_valid) begin
                        r_valid[w_idx][r_victim] <= 1'b1;
                        r_dirty[w_idx][r_victim] <= 1'b0;
                        r_retry                  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Request latch and tag/data arrays (no reset: contents qualified by valid)
    always_ff @(posedge clk) begin
        if ((r_state == S_IDLE) && bus.cpu_req_valid) begin
            r_addr  <= bus.cpu_addr;
            r_we    <= bus.cpu_req_type;
            r_wdata <= bus.cpu_wdata;
        end
        if ((r_state == S_REFILL_WAIT) && bus.mem_resp_valid) begin
            r_tag[w_idx][r_victim]  <= w_tag;
            r_data[w_idx][r_victim] <= bus.mem_rdata;
        end else if ((r_state == S_LOOKUP) && w_hit && r_we) begin
            r_data[w_idx][w_hit_way] <= w_line_new;
        end
    end

    assign bus.cpu_req_ready  = (r_state == S_IDLE);
    assign bus.cpu_resp_valid = r_resp_valid;
    assign bus.cpu_rdata      = r_rdata;
    assign hit_cnt            = r_hit_cnt;
    assign miss_cnt           = r_miss_cnt;
endmodule

// File: tb/tb_nway_wb_cache.sv
// Testbench for nway_wb_cache: directed scenarios followed by random traffic,
// checked against a recency-list cache model and a block memory model.
module tb_nway_wb_cache;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] hit_cnt, miss_cnt;

    nway_wb_cache_if #(.WORD_SIZE(32), .WORDS_PER_BLOCK(4), .ADDR_WIDTH(32)) bif ();

    nway_wb_cache #(
        .WORD_SIZE(32), .WORDS_PER_BLOCK(4), .NUM_BLOCKS(64), .NUM_WAYS(4), .ADDR_WIDTH(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bif), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: per set, lines in recency order (front = most recent)
    typedef struct {
        logic [25:0]  tag;
        bit           dirty;
        logic [127:0] data;
    } line_t;
    line_t        set_q [16][$];
    logic [127:0] mem_model [logic [29:0]];
    int           model_hits, model_misses;

    // Results of the last transaction
    logic [31:0]  last_rdata;
    int           last_nwb, last_nrf, last_resp_cycle;
    logic [29:0]  last_wb_addr, last_rf_addr;
    logic [127:0] last_wb_data;
    bit           last_stable;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] get_blk(input logic [29:0] a);
        logic [31:0] x;
        if (mem_model.exists(a)) return mem_model[a];
        x = {2'b00, a};
        return {32'hA000_0000 ^ x, x * 32'h9E37_79B1, ~x, x + 32'h0101_0101};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) set_q[i].delete();
        model_hits   = 0;
        model_misses = 0;
    endtask

    task automatic model_access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                                output bit hit, output bit wb, output logic [29:0] wb_a,
                                output logic [127:0] wb_d, output logic [31:0] rd);
        logic [3:0]  idx = addr[5:2];
        logic [25:0] tag = addr[31:6];
        int          off = int'(addr[1:0]);
        int          pos = -1;
        line_t       ln;
        wb = 1'b0; wb_a = '0; wb_d = '0;
        for (int i = 0; i < set_q[idx].size(); i++) if (set_q[idx][i].tag == tag) pos = i;
        hit = (pos >= 0);
        if (hit) begin
            ln = set_q[idx][pos];
            set_q[idx].delete(pos);
            model_hits++;
        end else begin
            if (set_q[idx].size() == 4) begin
                ln = set_q[idx].pop_back();
                if (ln.dirty) begin
                    wb = 1'b1; wb_a = {ln.tag, idx}; wb_d = ln.data;
                end
            end
            ln.tag = tag; ln.dirty = 1'b0; ln.data = get_blk({tag, idx});
            model_misses++;
        end
        if (we) begin
            ln.data[off*32 +: 32] = wd;
            ln.dirty = 1'b1;
        end
        rd = ln.data[off*32 +: 32];
        set_q[idx].push_front(ln);
    endtask

    // One core access, called at a negedge; also plays the memory side
    task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd, input int stall);
        bit           e_hit, e_wb, got_resp = 1'b0, in_req = 1'b0, rf_pend = 1'b0, h_we = 1'b0;
        logic [29:0]  e_wb_a, h_addr = '0;
        logic [127:0] e_wb_d, h_data = '0;
        logic [31:0]  e_rd;
        int           wait_cnt = 0, held = 0, rsp_dly = 0;
        model_access(we, addr, wd, e_hit, e_wb, e_wb_a, e_wb_d, e_rd);
        last_nwb = 0; last_nrf = 0; last_stable = 1'b1; last_resp_cycle = 0; last_rdata = '0;
        chk("req_ready_idle", bif.cpu_req_ready, 1);
        bif.cpu_req_valid = 1'b1; bif.cpu_req_type = we; bif.cpu_addr = addr; bif.cpu_wdata = wd;
        @(posedge clk); #1;
        bif.cpu_req_valid = 1'b0;
        while (!got_resp && wait_cnt < 200) begin
            @(negedge clk);
            wait_cnt++;
            if (bif.mem_req_ready) begin
                bif.mem_req_ready = 1'b0;
                in_req = 1'b0;
                if (h_we) begin
                    last_nwb++; last_wb_addr = h_addr; last_wb_data = h_data;
                    mem_model[h_addr] = h_data;
                end else begin
                    last_nrf++; last_rf_addr = h_addr;
                    rf_pend = 1'b1; rsp_dly = int'($urandom_range(0, 2));
                end
            end
            if (bif.mem_resp_valid) bif.mem_resp_valid = 1'b0;
            if (rf_pend) begin
                if (rsp_dly == 0) begin
                    bif.mem_resp_valid = 1'b1; bif.mem_rdata = get_blk(last_rf_addr); rf_pend = 1'b0;
                end else rsp_dly--;
            end
            if (bif.cpu_resp_valid) begin
                got_resp = 1'b1; last_rdata = bif.cpu_rdata; last_resp_cycle = wait_cnt;
            end else if (bif.mem_req_valid) begin
                if (!in_req) begin
                    in_req = 1'b1; held = 0;
                    h_addr = bif.mem_addr; h_we = bif.mem_req_we; h_data = bif.mem_wdata;
                end else if (bif.mem_addr !== h_addr || bif.mem_req_we !== h_we ||
                             (h_we && bif.mem_wdata !== h_data)) begin
                    last_stable = 1'b0;
                end
                if (held >= stall) bif.mem_req_ready = 1'b1;
                else held++;
            end
        end
        chk("resp_seen", got_resp, 1);
        chk("rdata", last_rdata, e_rd);
        chk("refill_count", last_nrf, e_hit ? 0 : 1);
        chk("wb_count", last_nwb, e_wb ? 1 : 0);
        if (e_wb && last_nwb == 1) begin
            chk("wb_addr", last_wb_addr, e_wb_a);
            chk("wb_data", last_wb_data, e_wb_d);
        end
        if (!e_hit && last_nrf == 1) chk("rf_addr", last_rf_addr, addr[31:2]);
        if (e_hit) chk("hit_latency", last_resp_cycle, 2);
        chk("req_stable", last_stable, 1);
        chk("hit_cnt", hit_cnt, model_hits);
        chk("miss_cnt", miss_cnt, model_misses);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", bif.cpu_req_ready, 1);
        chk("rst_hit_cnt", hit_cnt, 0);
        chk("rst_miss_cnt", miss_cnt, 0);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    initial begin
        int          wcnt;
        logic [31:0] ra;
        rst_n = 1'b0;
        bif.cpu_req_valid = 1'b0; bif.cpu_req_type = 1'b0; bif.cpu_addr = '0; bif.cpu_wdata = '0;
        bif.mem_req_ready = 1'b0; bif.mem_resp_valid = 1'b0; bif.mem_rdata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_req_ready", bif.cpu_req_ready, 1);
        chk("reset_resp_valid", bif.cpu_resp_valid, 0);
        chk("reset_rdata", bif.cpu_rdata, 0);
        chk("reset_mem_valid", bif.mem_req_valid, 0);
        chk("reset_mem_addr", bif.mem_addr, 0);
        chk("reset_hit_cnt", hit_cnt, 0);
        chk("reset_miss_cnt", miss_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Cold read miss, clean refill
        mem_model[30'h41] = 128'hCAFEBABE_FEEDFACE_DEADBEEF_87654321;
        access(1'b0, 32'h104, 32'h0, 0);
        chk("s1_rdata", last_rdata, 32'h87654321);
        chk("s1_rf_addr", last_rf_addr, 30'h41);
        chk("s1_nreq", last_nwb + last_nrf, 1);
        chk("s1_miss", miss_cnt, 1);
        chk("s1_hit", hit_cnt, 0);

        // Read hit
        access(1'b0, 32'h106, 32'h0, 0);
        chk("s2_rdata", last_rdata, 32'hFEEDFACE);
        chk("s2_latency", last_resp_cycle, 2);
        chk("s2_nreq", last_nwb + last_nrf, 0);
        chk("s2_hit", hit_cnt, 1);

        // Write hit then read back
        access(1'b1, 32'h105, 32'h12345678, 0);
        chk("s3_wr_rdata", last_rdata, 32'h12345678);
        access(1'b0, 32'h105, 32'h0, 0);
        chk("s3_rdata", last_rdata, 32'h12345678);
        chk("s3_nreq", last_nwb + last_nrf, 0);

        // Dirty LRU eviction with a 5-cycle stalled writeback
        access(1'b0, 32'h144, 32'h0, 0);
        access(1'b0, 32'h184, 32'h0, 0);
        access(1'b0, 32'h1C4, 32'h0, 0);
        access(1'b0, 32'h204, 32'h0, 5);
        chk("s4_nwb", last_nwb, 1);
        chk("s4_wb_addr", last_wb_addr, 30'h41);
        chk("s4_wb_word1", last_wb_data[63:32], 32'h12345678);
        chk("s4_stable", last_stable, 1);
        chk("s4_rf_addr", last_rf_addr, 30'h81);

        // Touching 0x104 moves the victim to tag 5 (clean)
        do_reset();
        access(1'b0, 32'h104, 32'h0, 0);
        access(1'b1, 32'h105, 32'hA5A55A5A, 0);
        access(1'b0, 32'h144, 32'h0, 0);
        access(1'b0, 32'h184, 32'h0, 0);
        access(1'b0, 32'h1C4, 32'h0, 0);
        access(1'b0, 32'h104, 32'h0, 0);
        access(1'b0, 32'h204, 32'h0, 2);
        chk("s5_nwb", last_nwb, 0);
        chk("s5_rf_addr", last_rf_addr, 30'h81);
        access(1'b0, 32'h104, 32'h0, 0);
        chk("s5_104_hit", last_nrf, 0);
        access(1'b0, 32'h144, 32'h0, 0);
        chk("s5_144_miss", last_nrf, 1);

        // Reset while a refill request is stalled: request drops at once
        do_reset();
        bif.cpu_req_valid = 1'b1; bif.cpu_req_type = 1'b0; bif.cpu_addr = 32'h304;
        @(posedge clk); #1;
        bif.cpu_req_valid = 1'b0;
        wcnt = 0;
        while (!bif.mem_req_valid && wcnt < 20) begin @(negedge clk); wcnt++; end
        chk("s6_req_seen", bif.mem_req_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_async_drop", bif.mem_req_valid, 0);
        chk("s6_async_ready", bif.cpu_req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in REFILL_WAIT with a refill response arriving during reset
        bif.cpu_req_valid = 1'b1; bif.cpu_req_type = 1'b0; bif.cpu_addr = 32'h304;
        @(posedge clk); #1;
        bif.cpu_req_valid = 1'b0;
        wcnt = 0;
        while (!bif.mem_req_valid && wcnt < 20) begin @(negedge clk); wcnt++; end
        chk("s6b_req_seen", bif.mem_req_valid, 1);
        bif.mem_req_ready = 1'b1;
        @(negedge clk);
        bif.mem_req_ready = 1'b0;
        #2 rst_n = 1'b0;
        bif.mem_resp_valid = 1'b1; bif.mem_rdata = {128{1'b1}};
        #1;
        chk("s6b_mem_valid", bif.mem_req_valid, 0);
        chk("s6b_resp_valid", bif.cpu_resp_valid, 0);
        @(posedge clk); #1;
        chk("s6b_resp_after_edge", bif.cpu_resp_valid, 0);
        @(negedge clk);
        bif.mem_resp_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        chk("s6b_ready", bif.cpu_req_ready, 1);
        chk("s6b_miss_cnt0", miss_cnt, 0);
        access(1'b0, 32'h104, 32'h0, 0);
        chk("s6b_104_miss", last_nrf, 1);
        chk("s6b_miss_cnt1", miss_cnt, 1);
        access(1'b0, 32'h304, 32'h0, 0);
        chk("s6b_304_not_installed", last_nrf, 1);

        // Random traffic over a few sets with more tags than ways
        do_reset();
        for (int i = 0; i < 150; i++) begin
            ra = {26'($urandom_range(0, 5)), 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            access(1'($urandom_range(0, 1)), ra, $urandom, int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
